fir_partial_sum_combiner: RTL
=============================

Name: fir_partial_sum_combiner

Overview:
- Stage directly downstream of the FIR lanes in the massively parallel FIR.
- Each FIR lane emits a 2*DATA_SIZE partial dot product `y_out`, qualified by a one-cycle `valid_strobe_out`. This block collects one partial result per lane per sample frame.
- When all lanes have reported, it sums the partials sequentially, rescales (round, shift), saturates to DATA_SIZE and emits one output sample with a one-cycle strobe.
- Lane outputs tolerate skewed completion times.

Parameters:
- NUM_FIR, 4: number of FIR lanes combined; must be ≥1.
- DATA_SIZE, 16: output sample width. Lane partials are 2*DATA_SIZE wide.
- OUT_SHIFT, 15: arithmetic right shift applied to the sum (Q15 coefficients); range 0 to 2*DATA_SIZE-1.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, synchronous, active-low
- valid_strobe_in  in  NUM_FIR  per-lane one-cycle strobe; bit i qualifies lane i
- y_in  in  NUM_FIR*2*DATA_SIZE  packed lane partials; lane i at bits [i*2*DATA_SIZE +: 2*DATA_SIZE]; signed two's complement
- sample_out  out  DATA_SIZE  combined, rounded, saturated sample; signed
- valid_strobe_out  out  1  one-cycle pulse; sample_out is new
- overflow_out  out  1  sample_out was saturated; valid together with valid_strobe_out
- overrun_o  out  1  sticky; a lane strobed again before its previous value was consumed
- busy_o  out  1  high while state is not IDLE

Behaviour:
- Single clock domain. Reset is synchronous and active-low: on a clk_i edge with rst_ni=0, all registers clear.
  - Values after reset: state=IDLE, pending=0, lane regs=0, acc=0, idx=0, sample_out=0, valid_strobe_out=0, overflow_out=0, overrun_o=0.
  - Reset mid-operation aborts the frame; no strobe is emitted for the aborted frame.
- Capture, evaluated every cycle and independent of state:
  - If valid_strobe_in[i]=1, lane_reg[i] <= lane i slice of y_in and pending[i] <= 1.
  - If pending[i] was already 1, the value is overwritten and overrun_o <= 1.
  - overrun_o stays set until reset.
- Accumulator width: ACC_W = 2*DATA_SIZE + clog2(NUM_FIR), with clog2(1)=0. Lane values are sign-extended into ACC_W; no internal overflow is possible.
- FSM states: IDLE, ACCUM, SCALE.
  - IDLE: when &pending=1, go to ACCUM, acc <= 0, idx <= 0.
  - ACCUM: each cycle acc <= acc + sext(lane_reg[idx]) and idx <= idx+1. When idx==NUM_FIR-1, clear pending (all bits) and go to SCALE.
    - A strobe arriving in the same cycle as this clear wins: that lane's pending stays 1 and no overrun is flagged.
  - SCALE: single cycle, then go to IDLE.
    - r = acc + (OUT_SHIFT>0 ? 2^(OUT_SHIFT-1) : 0), computed in ACC_W+1 bits.
    - s = r >>> OUT_SHIFT (arithmetic shift).
    - Saturate s to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
    - Register sample_out; valid_strobe_out <= 1; overflow_out <= 1 if clamping occurred, else 0.
- valid_strobe_out is high for exactly one cycle per frame.
- overflow_out is valid only in that cycle and returns to 0 with the strobe.
- sample_out holds its value until the next frame.
- Latency: with the last lane strobe sampled at edge E0, valid_strobe_out is high in the cycle after edge E0+NUM_FIR+2. For NUM_FIR=4, that is 6 clocks.
- Throughput: at most one frame per NUM_FIR+2 cycles.
  - Strobes for the next frame may arrive at any time once the corresponding pending bit has cleared.
  - An early strobe for a lane still pending in the current frame is an overrun.
- Rounding is round-half-up (toward +inf at ties). Example: -0.5 LSB rounds to 0.
- busy_o = (state != IDLE).

Test Plan:
- Reset (NUM_FIR=4, OUT_SHIFT=15): hold rst_ni=0 for 3 cycles → all outputs 0, busy_o=0.
- All lanes strobed in the same cycle, each y=0x00008000 → sum 0x20000. Required: sample_out=4, overflow_out=0, valid_strobe_out high for 1 cycle exactly 6 clocks after the strobe edge.
- Staggered strobes on lanes 0..3 at cycles 0, 3, 5, 9 with y=0x00010000 each → exactly one output strobe, sample_out=8, asserted 6 clocks after the cycle-9 edge. No strobe occurs earlier.
- Saturation:
  - All y=0x7FFFFFFF → sample_out=32767, overflow_out=1.
  - Next frame, all y=0x80000000 → sample_out=-32768, overflow_out=1.
- Rounding, lanes 1..3 at 0:
  - y0=0x00004000 → sample_out=1.
  - y0=0xFFFFC000 → sample_out=0.
  - y0=0x00003FFF → sample_out=0.
  - y0=0xFFFFBFFF → sample_out=-1.
- Overrun and abort:
  - Strobe lane 1 with 5, then with 7, before lane 3 arrives (others 0, OUT_SHIFT=0) → sample_out=7, overrun_o=1 and stays high.
  - Assert rst_ni=0 during ACCUM → next cycle busy_o=0, no valid_strobe_out, overrun_o=0.

Source files
------------

// File: rtl/fir_partial_sum_combiner_if.sv
// Lane-partial input bus and combined-sample output bus of the FIR partial sum combiner.
interface fir_partial_sum_combiner_if #(
  parameter int NUM_FIR   = 4,
  parameter int DATA_SIZE = 16
);
  logic [NUM_FIR-1:0]             valid_strobe_in;
  logic [NUM_FIR*2*DATA_SIZE-1:0] y_in;
  logic signed [DATA_SIZE-1:0]    sample_out;
  logic                           valid_strobe_out;
  logic                           overflow_out;
  logic                           overrun_o;
  logic                           busy_o;

  modport master (
    output valid_strobe_in, y_in,
    input  sample_out, valid_strobe_out, overflow_out, overrun_o, busy_o
  );

  modport slave (
    input  valid_strobe_in, y_in,
    output sample_out, valid_strobe_out, overflow_out, overrun_o, busy_o
  );
endinterface

// File: rtl/fir_partial_sum_combiner.sv
// Collects one partial dot product per FIR lane, sums them sequentially, then
// rounds half-up, shifts and saturates into one output sample per frame.
module fir_partial_sum_combiner #(
  parameter int NUM_FIR   = 4,
  parameter int DATA_SIZE = 16,
  parameter int OUT_SHIFT = 15
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  fir_partial_sum_combiner_if.slave bus
);
  localparam int unsigned LANE_W = 2 * DATA_SIZE;
  localparam int unsigned ACC_W  = LANE_W + $clog2(NUM_FIR);
  localparam int unsigned IDX_W  = (NUM_FIR > 1) ? $clog2(NUM_FIR) : 1;
  localparam int unsigned RSH    = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIR - 1);

  localparam logic signed [ACC_W:0] ROUND_C =
    (OUT_SHIFT > 0) ? ({{ACC_W{1'b0}}, 1'b1} << RSH) : '0;
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W + 2 - DATA_SIZE){1'b0}}, {(DATA_SIZE - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W + 2 - DATA_SIZE){1'b1}}, {(DATA_SIZE - 1){1'b0}}};

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] SCALE = 2'd2;

  logic [1:0]                  state;
  logic [NUM_FIR-1:0]          pending;
  logic signed [LANE_W-1:0]    lane_reg [NUM_FIR];
  logic signed [ACC_W-1:0]     acc;
  logic [IDX_W-1:0]            idx;
  logic signed [DATA_SIZE-1:0] sample_q;
  logic                        valid_q;
  logic                        ovf_q;
  logic                        overrun_q;

  logic                        clear_pending;
  logic signed [ACC_W:0]       rounded;
  logic signed [ACC_W:0]       shifted;
  logic                        sat_hi;
  logic                        sat_lo;

  assign clear_pending = (state == ACCUM) && (idx == LAST_IDX);

  always_comb begin
    rounded = (ACC_W + 1)'(acc) + ROUND_C;
    shifted = rounded >>> OUT_SHIFT;
    sat_hi  = shifted > SAT_MAX;
    sat_lo  = shifted < SAT_MIN;
  end

  // Capture runs regardless of FSM state; a strobe coinciding with the
  // end-of-frame clear keeps its pending bit and is not an overrun.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending   <= '0;
      overrun_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_FIR; i++) begin
        lane_reg[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_FIR; i++) begin
        if (bus.valid_strobe_in[i]) begin
          lane_reg[i] <= bus.y_in[i*LANE_W +: LANE_W];
          pending[i]  <= 1'b1;
          if (pending[i] && !clear_pending) begin
            overrun_q <= 1'b1;
          end
        end else if (clear_pending) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= IDLE;
      acc      <= '0;
      idx      <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (&pending) begin
            state <= ACCUM;
            acc   <= '0;
            idx   <= '0;
          end
        end
        ACCUM: begin
          acc <= acc + ACC_W'(lane_reg[idx]);
          idx <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            state <= SCALE;
          end
        end
        SCALE: begin
          state   <= IDLE;
          valid_q <= 1'b1;
          ovf_q   <= sat_hi | sat_lo;
          if (sat_hi) begin
            sample_q <= SAT_MAX[DATA_SIZE-1:0];
          end else if (sat_lo) begin
            sample_q <= SAT_MIN[DATA_SIZE-1:0];
          end else begin
            sample_q <= shifted[DATA_SIZE-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sample_out       = sample_q;
  assign bus.valid_strobe_out = valid_q;
  assign bus.overflow_out     = ovf_q;
  assign bus.overrun_o        = overrun_q;
  assign bus.busy_o           = (state != IDLE);
endmodule
